// File: rtl/alu_mc.sv
// alu_mc: multi-cycle registered ALU with a tristate result bus.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier (op 110).
// Without it, op 110 completes in one cycle and changes nothing.
module alu_mc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic             out_en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] prod_hi,
   output logic             busy,
   output logic             done,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_MUL = 3'b110,
      OP_CMP = 3'b111
   } op_t;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

   state_t           state_q, state_d;
   op_t              op_c;
   logic [WIDTH-1:0] result;
   logic [WIDTH:0]   add_full, sub_full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, wr_res, wr_flags, go_mul;
   logic             accept;

   assign op_c     = op_t'(op);
   assign add_full = {1'b0, A} + {1'b0, B};
   assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
   assign accept   = (state_q == S_IDLE) && start;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign out      = out_en ? result : 'z;

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] a_q, acc_q, mlo_q, prod_hi_q, next_hi, next_lo;
   logic [WIDTH:0]   mul_sum;
   logic [CW-1:0]    cnt_q;

   // One shift-add step: add A into the high half if the multiplier LSB is set, then shift right.
   assign mul_sum = {1'b0, acc_q} + (mlo_q[0] ? {1'b0, a_q} : '0);
   assign next_hi = mul_sum[WIDTH:1];
   assign next_lo = {mul_sum[0], mlo_q[WIDTH-1:1]};
   assign prod_hi = prod_hi_q;
`else
   assign prod_hi = '0;
`endif

   // Single-cycle operation decode: value, carry, overflow and which registers to update.
   always_comb begin
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      wr_res   = 1'b1;
      wr_flags = 1'b1;
      go_mul   = 1'b0;
      case (op_c)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
            wr_res  = (op_c == OP_SUB);
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_SHL: begin
            alu_res = {A[WIDTH-2:0], 1'b0};
            alu_c   = A[MSB];
         end
         OP_MUL: begin
            wr_res   = 1'b0;
            wr_flags = 1'b0;
`ifdef ALU_MUL_EN
            go_mul   = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Next-state logic: IDLE -> (MUL ->) DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = go_mul ? state_t'(1) : S_DONE;
`ifdef ALU_MUL_EN
         S_MUL:  if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register; clr wins over any pending start.
   always_ff @(posedge clk) begin
      if (clr) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Result, flag and multiplier registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
`ifdef ALU_MUL_EN
         prod_hi_q <= '0;
         a_q       <= '0;
         acc_q     <= '0;
         mlo_q     <= '0;
         cnt_q     <= '0;
`endif
      end else if (accept) begin
         if (wr_res) result <= alu_res;
         if (wr_flags) begin
            cout <= alu_c;
            zero <= (alu_res == '0);
            neg  <= alu_res[MSB];
            ovf  <= alu_v;
`ifdef ALU_MUL_EN
            prod_hi_q <= '0;
`endif
         end
`ifdef ALU_MUL_EN
         if (go_mul) begin
            a_q   <= A;
            acc_q <= '0;
            mlo_q <= B;
            cnt_q <= '0;
         end
      end else if (state_q == S_MUL) begin
         acc_q <= next_hi;
         mlo_q <= next_lo;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            result    <= next_lo;
            prod_hi_q <= next_hi;
            cout      <= (next_hi != '0);
            zero      <= (next_lo == '0);
            neg       <= next_lo[MSB];
            ovf       <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with hand-computed expectations for alu_mc (WIDTH=8).
// The multiplier section is selected by ALU_MUL_EN, matching the RTL build.
module tb_alu_mc;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clr, start, out_en;
   logic [W-1:0] a, b;
   logic [2:0]   op;
   logic [W-1:0] out, prod_hi;
   logic         busy, done, cout, zero, neg, ovf;
   logic [W-1:0] zz;
   int           n_total = 0;
   int           n_bad = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .A(a), .B(b), .op(op), .start(start), .out_en(out_en),
      .out(out), .prod_hi(prod_hi), .busy(busy), .done(done),
      .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic c, input logic z, input logic n, input logic v);
      check({tag, "_cout"}, 32'(cout), 32'(c));
      check({tag, "_zero"}, 32'(zero), 32'(z));
      check({tag, "_neg"},  32'(neg),  32'(n));
      check({tag, "_ovf"},  32'(ovf),  32'(v));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   int cycles;
   int stray;

   initial begin
      clr = 1'b1; start = 1'b0; out_en = 1'b1; a = '0; b = '0; op = '0;
      zz = 'z;
      tick();
      tick();
      // clr and start together: reset wins
      op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_out",  32'(out),     'h00);
      check("rst_hi",   32'(prod_hi), 'h00);
      check("rst_busy", 32'(busy),    0);
      check("rst_done", 32'(done),    0);
      check_flags("rst", 0, 0, 0, 0);
      clr = 1'b0;

      issue(3'b000, 8'h7F, 8'h01);
      check("add_out",  32'(out),  'h80);
      check_flags("add", 0, 0, 1, 1);
      check("add_done", 32'(done), 1);
      check("add_busy", 32'(busy), 1);
      tick();
      check("add_done_end", 32'(done), 0);
      check("add_busy_end", 32'(busy), 0);

      issue(3'b001, 8'h05, 8'h05);
      check("sub_out", 32'(out), 'h00);
      check_flags("sub", 1, 1, 0, 0);
      tick();

      issue(3'b111, 8'h03, 8'h04);
      check("cmp_out", 32'(out), 'h00);
      check_flags("cmp", 0, 0, 1, 0);
      tick();

      issue(3'b000, 8'hFF, 8'h01);
      check("addc_out", 32'(out), 'h00);
      check_flags("addc", 1, 1, 0, 0);
      tick();

      issue(3'b001, 8'h80, 8'h01);
      check("subv_out", 32'(out), 'h7F);
      check_flags("subv", 1, 0, 0, 1);
      tick();

      issue(3'b001, 8'h00, 8'h01);
      check("subb_out", 32'(out), 'hFF);
      check_flags("subb", 0, 0, 1, 0);
      tick();

      issue(3'b010, 8'hF0, 8'h3C);
      check("and_out", 32'(out), 'h30);
      check_flags("and", 0, 0, 0, 0);
      tick();

      issue(3'b011, 8'h81, 8'h02);
      check("or_out", 32'(out), 'h83);
      check_flags("or", 0, 0, 1, 0);
      tick();

      issue(3'b101, 8'h81, 8'h00);
      check("shl_out", 32'(out), 'h02);
      check_flags("shl", 1, 0, 0, 0);
      tick();

      // start held high through the DONE cycle must not launch a second op
      op = 3'b100; a = 8'hF0; b = 8'hFF; start = 1'b1;
      tick();
      check("xor_out",  32'(out),  'h0F);
      check("xor_done", 32'(done), 1);
      a = 8'h00;
      tick();
      start = 1'b0;
      check("xor_hold", 32'(out),  'h0F);
      check("xor_idle", 32'(busy), 0);
      check("xor_nodone", 32'(done), 0);
      check_flags("xor", 0, 0, 0, 0);

      out_en = 1'b0;
      #1;
      check("oe_off", 32'(out), 32'(zz));
      out_en = 1'b1;
      #1;
      check("oe_on", 32'(out), 'h0F);

`ifdef ALU_MUL_EN
      issue(3'b110, 8'hFF, 8'hFF);
      check("mul_busy", 32'(busy), 1);
      check("mul_early_done", 32'(done), 0);
      cycles = 0;
      while (!done && cycles < 20) begin
         if (cycles == 2) begin
            op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
         end
         tick();
         start = 1'b0;
         cycles++;
      end
      check("mul_cycles", 32'(cycles), 8);
      check("mul_lo", 32'(out), 'h01);
      check("mul_hi", 32'(prod_hi), 'hFE);
      check_flags("mul", 1, 0, 0, 0);
      tick();
      check("mul_after_busy", 32'(busy), 0);
      check("mul_after_out",  32'(out),  'h01);

      issue(3'b110, 8'h10, 8'h10);
      tick();
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort_out",  32'(out),     'h00);
      check("abort_hi",   32'(prod_hi), 'h00);
      check("abort_busy", 32'(busy),    0);
      check("abort_done", 32'(done),    0);
      check_flags("abort", 0, 0, 0, 0);
      stray = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (done) stray++;
         tick();
      end
      check("abort_stray_done", 32'(stray), 0);

      issue(3'b000, 8'h01, 8'h02);
      check("post_add_out",  32'(out),  'h03);
      check("post_add_done", 32'(done), 1);
      check_flags("post_add", 0, 0, 0, 0);
      tick();
`else
      issue(3'b110, 8'h01, 8'h02);
      check("nomul_out",  32'(out),     'h0F);
      check("nomul_hi",   32'(prod_hi), 'h00);
      check("nomul_done", 32'(done),    1);
      check_flags("nomul", 0, 0, 0, 0);
      tick();
      check("nomul_done_end", 32'(done), 0);
      check("nomul_busy_end", 32'(busy), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
